// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Interface bundling the duty-ramp controller's configuration inputs and
// its duty/status outputs.
//   master : drives target_duty, ramp_en, step_size, tick_div, period_wrap;
//            receives duty_out, busy, done
//   slave  : the ramp controller itself
// Parameters: DIV_W (prescale/tick_div width), STEP_W (step_size width).
interface pwm_duty_ramp_ctrl_if #(
    parameter int DIV_W  = 8,
    parameter int STEP_W = 4
);
    logic [7:0]        target_duty;
    logic              ramp_en;
    logic [STEP_W-1:0] step_size;
    logic [DIV_W-1:0]  tick_div;
    logic              period_wrap;
    logic [7:0]        duty_out;
    logic              busy;
    logic              done;

    modport master (
        output target_duty, ramp_en, step_size, tick_div, period_wrap,
        input  duty_out, busy, done
    );

    modport slave (
        input  target_duty, ramp_en, step_size, tick_div, period_wrap,
        output duty_out, busy, done
    );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps the PWM duty cycle from its current value towards the SPI-written
// target in steps of step_size (0 treated as 1), one step every tick_div+1
// clocks, giving a fade instead of a jump.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous reset, active low
//   bus    pwm_duty_ramp_ctrl_if.slave:
//            target_duty, ramp_en, step_size, tick_div, period_wrap (in)
//            duty_out, busy, done (out)
// Build option: RAMP_PERIOD_SYNC_EN -- when defined, due steps and bypass
// updates are held until period_wrap so duty only moves on PWM period
// boundaries. When undefined, period_wrap is ignored.
//
// state  | meaning
// IDLE   | duty_out settled (equals target, or bypassing)
// UP     | ramping duty_out upwards towards target
// DOWN   | ramping duty_out downwards towards target
module pwm_duty_ramp_ctrl #(
    parameter int DIV_W  = 8,
    parameter int STEP_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pwm_duty_ramp_ctrl_if.slave     bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;

    logic [1:0]       state;
    logic [DIV_W-1:0] count;
    logic [7:0]       duty_q;
    logic             busy_q;
    logic             done_q;

    logic [8:0] step_eff;
    logic [8:0] duty_ext;
    logic [8:0] tgt_ext;
    logic [8:0] diff;
    logic [8:0] duty_next;
    logic       tgt_above;
    logic       lands;
    logic       step_due;
    logic       step_go;
    logic       bypass_go;

    // 9-bit arithmetic so the step sum/difference can never wrap; a step
    // that would reach or pass the target lands exactly on it instead.
    always_comb begin
        step_eff  = (bus.step_size == '0) ? 9'd1 : {{(9-STEP_W){1'b0}}, bus.step_size};
        duty_ext  = {1'b0, duty_q};
        tgt_ext   = {1'b0, bus.target_duty};
        tgt_above = tgt_ext > duty_ext;
        diff      = tgt_above ? (tgt_ext - duty_ext) : (duty_ext - tgt_ext);
        lands     = diff <= step_eff;
        duty_next = tgt_above ? (duty_ext + step_eff) : (duty_ext - step_eff);
        step_due  = count == bus.tick_div;
    end

`ifdef RAMP_PERIOD_SYNC_EN
    assign step_go   = step_due & bus.period_wrap;
    assign bypass_go = bus.period_wrap;
`else
    logic unused_period_wrap;
    assign unused_period_wrap = bus.period_wrap;
    assign step_go   = step_due;
    assign bypass_go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            duty_q <= 8'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!bus.ramp_en) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                count  <= '0;
                if (bypass_go) begin
                    duty_q <= bus.target_duty;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.target_duty != duty_q) begin
                            state  <= tgt_above ? S_UP : S_DOWN;
                            busy_q <= 1'b1;
                            count  <= '0;
                        end
                    end
                    S_UP, S_DOWN: begin
                        if (step_go) begin
                            count <= '0;
                            if (lands) begin
                                duty_q <= bus.target_duty;
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                // direction re-evaluated every step so a
                                // retarget across duty_out reverses here
                                duty_q <= duty_next[7:0];
                                state  <= tgt_above ? S_UP : S_DOWN;
                            end
                        end else if (!step_due) begin
                            count <= count + 1'b1;
                        end
                        // due but waiting for period_wrap: count parks at tick_div
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        count  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.duty_out = duty_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
module tb_pwm_duty_ramp_ctrl;
    localparam int DIV_W  = 8;
    localparam int STEP_W = 5;   // wide enough for step=16 scenarios

    logic clk;
    logic rst_n;

    pwm_duty_ramp_ctrl_if #(.DIV_W(DIV_W), .STEP_W(STEP_W)) bus ();

    pwm_duty_ramp_ctrl #(.DIV_W(DIV_W), .STEP_W(STEP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst_n;
        logic [7:0]        tgt;
        logic              en;
        logic [STEP_W-1:0] stp;
        logic [DIV_W-1:0]  div;
        logic              wrap;
        logic [7:0]        exp_duty;
        logic              exp_busy;
        logic              exp_done;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] duty;
        logic       busy;
        logic       done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(int r, int tgt, int en, int stp, int div, int wrap,
                                int d, int b, int dn);
        vec_t v;
        v.rst_n    = (r != 0);
        v.tgt      = 8'(tgt);
        v.en       = (en != 0);
        v.stp      = STEP_W'(stp);
        v.div      = DIV_W'(div);
        v.wrap     = (wrap != 0);
        v.exp_duty = 8'(d);
        v.exp_busy = (b != 0);
        v.exp_done = (dn != 0);
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d] actual %0d required %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [7:0] tgt, logic en, logic [STEP_W-1:0] stp,
                         logic [DIV_W-1:0] div, logic wrap);
        rst_n           = r;
        bus.target_duty = tgt;
        bus.ramp_en     = en;
        bus.step_size   = stp;
        bus.tick_div    = div;
        bus.period_wrap = wrap;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog timeout actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        logic got;
        logic [7:0] prev;
        logic w;

        // reset with target 0x80
        add(0, 8'h80, 1, 16, 3, 1, 0, 0, 0);
        add(0, 8'h80, 1, 16, 3, 1, 0, 0, 0);
        add(1, 0, 1, 16, 3, 1, 0, 0, 0);
        // ramp up 0 -> 64, step 16, tick_div 3
        add(1, 64, 1, 16, 3, 1, 0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < 3; j++) add(1, 64, 1, 16, 3, 1, 16*(k-1), 1, 0);
            add(1, 64, 1, 16, 3, 1, 16*k, (k != 4) ? 1 : 0, (k == 4) ? 1 : 0);
        end
        add(1, 64, 1, 16, 3, 1, 64, 0, 0);
        // clamp down 100 -> 5, step 15, tick_div 0
        add(1, 100, 0, 15, 0, 1, 100, 0, 0);
        add(1, 5, 1, 15, 0, 1, 100, 1, 0);
        for (int k = 1; k <= 6; k++) add(1, 5, 1, 15, 0, 1, 100 - 15*k, 1, 0);
        add(1, 5, 1, 15, 0, 1, 5, 0, 1);
        add(1, 5, 1, 15, 0, 1, 5, 0, 0);
        // reversal: up towards 200, retarget to 20 at duty 48
        add(1, 0, 0, 16, 0, 1, 0, 0, 0);
        add(1, 200, 1, 16, 0, 1, 0, 1, 0);
        for (int k = 1; k <= 3; k++) add(1, 200, 1, 16, 0, 1, 16*k, 1, 0);
        add(1, 20, 1, 16, 0, 1, 32, 1, 0);
        add(1, 20, 1, 16, 0, 1, 20, 0, 1);
        add(1, 20, 1, 16, 0, 1, 20, 0, 0);
        // bypass mid-ramp
        add(1, 200, 1, 1, 0, 1, 20, 1, 0);
        add(1, 200, 1, 1, 0, 1, 21, 1, 0);
        add(1, 200, 1, 1, 0, 1, 22, 1, 0);
        add(1, 8'hAA, 0, 1, 0, 1, 8'hAA, 0, 0);
        add(1, 8'hAA, 0, 1, 0, 1, 8'hAA, 0, 0);
        add(1, 8'hAA, 1, 1, 0, 1, 8'hAA, 0, 0);
        // step_size 0 behaves as 1
        add(1, 8'hAC, 1, 0, 0, 1, 8'hAA, 1, 0);
        add(1, 8'hAC, 1, 0, 0, 1, 8'hAB, 1, 0);
        add(1, 8'hAC, 1, 0, 0, 1, 8'hAC, 0, 1);
        add(1, 8'hAC, 1, 0, 0, 1, 8'hAC, 0, 0);
        // top clamp, no overflow past 255
        add(1, 8'hF8, 0, 15, 0, 1, 8'hF8, 0, 0);
        add(1, 8'hFF, 1, 15, 0, 1, 8'hF8, 1, 0);
        add(1, 8'hFF, 1, 15, 0, 1, 8'hFF, 0, 1);
        // reset mid-ramp
        add(1, 0, 1, 1, 0, 1, 8'hFF, 1, 0);
        add(1, 0, 1, 1, 0, 1, 8'hFE, 1, 0);
        add(0, 0, 1, 1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 1, 0, 1, 0, 0, 0);

        drive(1'b0, 8'h80, 1'b0, '0, '0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].tgt, vecs[i].en, vecs[i].stp, vecs[i].div, vecs[i].wrap);
            e.idx  = i;
            e.duty = vecs[i].exp_duty;
            e.busy = vecs[i].exp_busy;
            e.done = vecs[i].exp_done;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", i, 0, 1);
            end else begin
                e = sb.pop_front();
                chk("duty", e.idx, int'(bus.duty_out), int'(e.duty));
                chk("busy", e.idx, int'(bus.busy), int'(e.busy));
                chk("done", e.idx, int'(bus.done), int'(e.done));
            end
        end

`ifdef RAMP_PERIOD_SYNC_EN
        // duty moves only on period_wrap edges; 0 -> 40 step 4 needs 10 wraps
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            w = ((c % 10) == 9);
            drive(1'b1, 8'd40, 1'b1, 5'd4, 8'd0, w);
            prev = bus.duty_out;
            @(posedge clk);
            #1;
            if (bus.duty_out != prev) chk("change_off_wrap", c, int'(w), 1);
        end
        chk("sync_final_duty", 0, int'(bus.duty_out), 40);
        chk("sync_final_busy", 0, int'(bus.busy), 0);
        // bypass also waits for the period boundary
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 8'h55, 1'b0, 5'd4, 8'd0, (c == 2));
            @(posedge clk);
            #1;
            chk("sync_bypass", c, int'(bus.duty_out), (c == 2) ? 8'h55 : 40);
        end
`else
        // period_wrap held low must not stall steps; 0 -> 24 step 8 tick_div 1
        @(negedge clk);
        drive(1'b1, 8'd24, 1'b1, 5'd8, 8'd1, 1'b0);
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) got = 1'b1;
        end
        chk("landing_seen", 0, int'(got), 1);
        chk("landing_latency", 0, n, 7);
        chk("landing_duty", 0, int'(bus.duty_out), 24);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 0, int'(bus.done), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
